arm_sram_controller: RTL and testbench



---
 rtl/arm_mem_pkg.sv | 7 +
 rtl/arm_sram_controller.sv | 83 ++++++++
 tb/tb_arm_sram_controller.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared FSM state type and SRAM geometry defaults for the MEM-stage SRAM controller
package arm_mem_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam int ADDR_BASE_DEF = 1024;
   localparam int SRAM_DATA_W = 16;
   localparam int SRAM_ADDR_W_DEF = 18;
endpackage

// File: rtl/arm_sram_controller.sv
// arm_sram_controller: splits 32-bit MEM-stage loads/stores into two 16-bit SRAM accesses plus a fixed wait (optional SRAM_RANGE_CHECK_EN)
module arm_sram_controller
   import arm_mem_pkg::*;
#(
   parameter int ADDR_BASE = ADDR_BASE_DEF,
   parameter int SRAM_ADDR_W = SRAM_ADDR_W_DEF,
   parameter int ACCESS_CYCLES = 6
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_en,
   input  logic                   wr_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_OE_N,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N
);
   state_t state, next_state;
   logic [3:0] cnt;
   logic op_wr, oor, oor_in, req, bus, unused;
   logic [SRAM_ADDR_W-2:0] word_q;
   logic [31:0] wdata, offset;
   logic [SRAM_DATA_W-1:0] dq_out;
   assign req = rd_en | wr_en;
   assign offset = address - 32'(ADDR_BASE);
   assign bus = state == BUSY && cnt < 4'd2;
   assign unused = ^offset;
`ifdef SRAM_RANGE_CHECK_EN
   assign oor_in = address < 32'(ADDR_BASE) || offset[31:2] >= 30'(1 << (SRAM_ADDR_W - 1));
`else
   assign oor_in = 1'b0;
`endif
   assign SRAM_DQ = bus && op_wr && !oor ? dq_out : 'z;
   // state register
   always_ff @(posedge clk)
      state <= rst ? IDLE : next_state;
   // next-state logic; DONE never samples the still-held request
   always_comb begin
      next_state = state;
      if (state == IDLE && req) next_state = BUSY;
      else if (state == BUSY && cnt == 4'(ACCESS_CYCLES - 1)) next_state = DONE;
      else if (state == DONE) next_state = IDLE;
   end
   // request latch, wait counter and load capture
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         op_wr <= 1'b0;
         oor <= 1'b0;
         word_q <= '0;
         wdata <= '0;
         read_data <= '0;
      end else begin
         if (state == IDLE && req) begin
            op_wr <= wr_en;
            oor <= oor_in;
            word_q <= offset[SRAM_ADDR_W:2];
            wdata <= write_data;
         end
         cnt <= state == BUSY ? cnt + 4'd1 : 4'd0;
         if (bus && !op_wr && cnt[0]) read_data[31:16] <= oor ? '0 : SRAM_DQ;
         if (bus && !op_wr && !cnt[0]) read_data[15:0] <= oor ? '0 : SRAM_DQ;
      end
   end
   // strobes and handshake; out-of-range accesses keep the chip deselected
   always_comb begin
      ready = (state == IDLE && !req) || state == DONE;
      SRAM_CE_N = !(bus && !oor);
      SRAM_WE_N = !(bus && !oor && op_wr);
      SRAM_OE_N = !(bus && !oor && !op_wr);
      SRAM_UB_N = !bus;
      SRAM_LB_N = !bus;
      SRAM_ADDR = bus ? {word_q, cnt[0]} : '0;
      dq_out = cnt[0] ? wdata[31:16] : wdata[15:0];
   end
endmodule

// File: tb/tb_arm_sram_controller.sv
// tb_arm_sram_controller: scoreboard bench with an inline 16-bit SRAM model and a word-level reference memory
module tb_arm_sram_controller;
   localparam int ACC = 6;
   typedef struct {
      bit ld;
      bit oor;
      logic [31:0] data;
      logic [17:0] a0;
   } exp_t;
   logic clk = 0, rst = 1, rd_en = 0, wr_en = 0;
   logic [31:0] address = 0, write_data = 0, read_data;
   logic ready, we_n, ce_n, oe_n, ub_n, lb_n;
   logic [17:0] sram_addr;
   wire [15:0] SRAM_DQ;
   logic [15:0] mem [0:(1<<18)-1];
   logic [31:0] ref_mem [int];
   exp_t exp_q[$];
   logic [17:0] seen_addr[$];
   int compared = 0, mismatched = 0, lowcnt = 0, wecnt = 0;

   arm_sram_controller dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(SRAM_DQ),
      .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
   );

   always #5 clk = ~clk;

   assign SRAM_DQ = !ce_n && !oe_n && we_n ? mem[sram_addr] : 16'hzzzz;

   initial begin
      for (int i = 0; i < (1 << 18); i++) mem[i] = 16'h0;
      forever begin
         @(posedge clk);
         if (!ce_n && !we_n) begin
            if (!lb_n) mem[sram_addr][7:0] = SRAM_DQ[7:0];
            if (!ub_n) mem[sram_addr][15:8] = SRAM_DQ[15:8];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   function automatic exp_t model(input bit wr, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      logic [31:0] w;
      int key;
      w = (a - 32'd1024) >> 2;
      key = int'(w & 32'h1FFFF);
      e.ld = !wr;
`ifdef SRAM_RANGE_CHECK_EN
      e.oor = a < 32'd1024 || w >= 32'h20000;
`else
      e.oor = 1'b0;
`endif
      e.a0 = {w[16:0], 1'b0};
      e.data = 32'h0;
      if (wr && !e.oor) ref_mem[key] = d;
      if (!wr && !e.oor && ref_mem.exists(key)) e.data = ref_mem[key];
      return e;
   endfunction

   task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit keep);
      int n = 0;
      rd_en = !wr;
      wr_en = wr;
      address = a;
      write_data = d;
      exp_q.push_back(model(wr, a, d));
      #1 chk("ready_drop", {31'b0, ready}, 32'd0);
      do begin
         @(negedge clk);
         n++;
      end while (!ready && n < 40);
      if (n >= 40) chk("access_timeout", n, 32'd0);
      @(posedge clk);
      #1;
      if (!keep) begin
         rd_en = 0;
         wr_en = 0;
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            lowcnt = 0;
            wecnt = 0;
            seen_addr.delete();
         end else if (!ready) begin
            lowcnt++;
            if (!we_n) wecnt++;
            if (!ce_n) seen_addr.push_back(sram_addr);
         end else if (lowcnt > 0) begin
            if (exp_q.size() == 0) chk("unexpected_access", lowcnt, 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("freeze_len", lowcnt, 32'(1 + ACC));
               chk("we_cycles", wecnt, (e.ld || e.oor) ? 32'd0 : 32'd2);
               chk("ce_cycles", seen_addr.size(), e.oor ? 32'd0 : 32'd2);
               if (!e.oor && seen_addr.size() == 2) begin
                  chk("addr_lo", 32'(seen_addr[0]), 32'(e.a0));
                  chk("addr_hi", 32'(seen_addr[1]), 32'(e.a0 | 18'd1));
               end
               if (e.ld) chk("read_data", read_data, e.data);
            end
            lowcnt = 0;
            wecnt = 0;
            seen_addr.delete();
         end else begin
            chk("idle_ce", {31'b0, ce_n}, 32'd1);
            chk("idle_we", {31'b0, we_n}, 32'd1);
         end
      end
   end

   initial begin
      logic [31:0] a;
      int sel, n;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'b0, ready}, 32'd1);
      chk("rst_strobes", {28'b0, ce_n, we_n, oe_n, ub_n & lb_n}, 32'hF);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_read_data", read_data, 32'd0);
      @(posedge clk);
      #1 rst = 0;
      access(1, 32'd1024, 32'hDEADBEEF, 0);
      chk("mem0", 32'(mem[0]), 32'h0000BEEF);
      chk("mem1", 32'(mem[1]), 32'h0000DEAD);
      access(1, 32'd1028, 32'h12345678, 1);
      access(0, 32'd1028, 32'h0, 0);
      repeat (10) begin
         @(negedge clk);
         chk("idle_ready", {31'b0, ready}, 32'd1);
      end
      @(posedge clk);
      #1;
      access(0, 32'd1024, 32'h0, 0);
      wr_en = 1;
      address = 32'd1032;
      write_data = 32'hCAFEF00D;
      void'(model(1, 32'd1032, 32'hCAFEF00D));
      repeat (4) @(posedge clk);
      #1;
      rst = 1;
      wr_en = 0;
      @(posedge clk);
      #1;
      chk("midrst_ready", {31'b0, ready}, 32'd1);
      chk("midrst_we", {31'b0, we_n}, 32'd1);
      chk("midrst_ce", {31'b0, ce_n}, 32'd1);
      chk("midrst_read_data", read_data, 32'd0);
      rst = 0;
      @(posedge clk);
      #1;
      access(0, 32'd1032, 32'h0, 1);
      access(1, 32'd1036, 32'h0BADC0DE, 0);
      access(0, 32'h00000100, 32'h0, 0);
      access(0, 32'd1036, 32'h0, 0);
      repeat (5) begin
         @(negedge clk);
         chk("held_no_retrigger", {31'b0, ready}, 32'd1);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         a = sel == 0 ? 32'd1024 - 4 * $urandom_range(1, 4) :
             sel == 1 ? 32'd1024 + 4 * (32'h20000 + $urandom_range(0, 15)) :
                        32'd1024 + 4 * $urandom_range(0, 15);
         access(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
         if (!rd_en && !wr_en) repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      rd_en = 0;
      wr_en = 0;
      n = 0;
      while (exp_q.size() > 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 32'd0);
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
